// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM encoding, counter width.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Wide enough for MUL_LAT-1 with MUL_LAT up to 15.
  localparam int CNT_W = 4;

  // Legal op codes run from OP_AND through OP_MUL; anything higher is rejected.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the result return and the shared ALU port.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_i;
  logic [2:0]       ctrl0_i;
  logic [WIDTH-1:0] a0_i;
  logic [WIDTH-1:0] b0_i;
  logic             req1_i;
  logic [2:0]       ctrl1_i;
  logic [WIDTH-1:0] a1_i;
  logic [WIDTH-1:0] b1_i;
  logic             gnt0_o;
  logic             gnt1_o;
  logic             done0_o;
  logic             done1_o;
  logic             err_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic [WIDTH-1:0] alu_data1_o;
  logic [WIDTH-1:0] alu_data2_o;
  logic [2:0]       alu_ctrl_o;
  logic [WIDTH-1:0] alu_data_i;
  logic             alu_zero_i;

  // The arbiter side.
  modport slave (
    input  req0_i, ctrl0_i, a0_i, b0_i, req1_i, ctrl1_i, a1_i, b1_i,
           alu_data_i, alu_zero_i,
    output gnt0_o, gnt1_o, done0_o, done1_o, err_o, result_o, zero_o,
           alu_data1_o, alu_data2_o, alu_ctrl_o
  );

  // The environment side: requesters plus the ALU itself.
  modport master (
    output req0_i, ctrl0_i, a0_i, b0_i, req1_i, ctrl1_i, a1_i, b1_i,
           alu_data_i, alu_zero_i,
    input  gnt0_o, gnt1_o, done0_o, done1_o, err_o, result_o, zero_o,
           alu_data1_o, alu_data2_o, alu_ctrl_o
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; last_i names the requester served last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  // A lone request wins outright; on contention the one not served last wins.
  assign gnt_o[0] = req_i[0] & (~req_i[1] |  last_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grants.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_arbiter_if.slave  bus
);

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               done0_q, done0_d, done1_q, done1_d;
  logic               err_q, err_d;

  logic [1:0]         pick;
  logic [2:0]         win_ctrl;
  logic [WIDTH-1:0]   win_a, win_b;

  rr_arb2 u_rr_arb2 (
    .req_i  ({bus.req1_i, bus.req0_i}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign win_ctrl = pick[1] ? bus.ctrl1_i : bus.ctrl0_i;
  assign win_a    = pick[1] ? bus.a1_i    : bus.a0_i;
  assign win_b    = pick[1] ? bus.b1_i    : bus.b0_i;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: leave IDLE on any request, leave EXEC when the hold count expires.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (|pick)        state_d = ST_EXEC;
      ST_EXEC: if (cnt_q == '0)  state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: latch the winner on grant, return the result on completion.
  always_comb begin
    last_d    = last_q;
    owner_d   = owner_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    ctrl_d    = ctrl_q;
    result_d  = result_q;
    zero_d    = zero_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err_d     = 1'b0;
    if (state_q == ST_IDLE) begin
      if (|pick) begin
        owner_d   = pick[1];
        last_d    = pick[1];
        illegal_d = !op_legal(win_ctrl);
        // An illegal code never reaches the ALU; it sees a harmless AND instead.
        ctrl_d    = op_legal(win_ctrl) ? win_ctrl : OP_AND;
        a_d       = win_a;
        b_d       = win_b;
        cnt_d     = (win_ctrl == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
        gnt0_d    = pick[0];
        gnt1_d    = pick[1];
      end
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        result_d = illegal_q ? '0   : bus.alu_data_i;
        zero_d   = illegal_q ? 1'b1 : bus.alu_zero_i;
        done0_d  = ~owner_q;
        done1_d  = owner_q;
        err_d    = illegal_q;
      end
    end
  end

  // Datapath registers.
  // NOTE: operand and result registers are reset too, because every output must read 0 in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= OP_AND;
      result_q  <= '0;
      zero_q    <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      owner_q   <= owner_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctrl_q    <= ctrl_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
    end
  end

  // Output decode: every output is a register image.
  always_comb begin
    bus.gnt0_o      = gnt0_q;
    bus.gnt1_o      = gnt1_q;
    bus.done0_o     = done0_q;
    bus.done1_o     = done1_q;
    bus.err_o       = err_q;
    bus.result_o    = result_q;
    bus.zero_o      = zero_q;
    bus.alu_data1_o = a_q;
    bus.alu_data2_o = b_q;
    bus.alu_ctrl_o  = ctrl_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural ALU on the shared port.
  logic [WIDTH-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl_o)
      3'b000:  alu_res = bus.alu_data1_o & bus.alu_data2_o;
      3'b001:  alu_res = bus.alu_data1_o | bus.alu_data2_o;
      3'b010:  alu_res = bus.alu_data1_o + bus.alu_data2_o;
      3'b011:  alu_res = bus.alu_data1_o - bus.alu_data2_o;
      3'b100:  alu_res = bus.alu_data1_o * bus.alu_data2_o;
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_data_i = alu_res;
  assign bus.alu_zero_i = (alu_res == '0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive0(input logic req, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req0_i = req; bus.ctrl0_i = op; bus.a0_i = a; bus.b0_i = b;
  endtask

  task automatic drive1(input logic req, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req1_i = req; bus.ctrl1_i = op; bus.a1_i = a; bus.b1_i = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"},   64'(bus.gnt0_o),      0);
    check({tag, "_gnt1"},   64'(bus.gnt1_o),      0);
    check({tag, "_done0"},  64'(bus.done0_o),     0);
    check({tag, "_done1"},  64'(bus.done1_o),     0);
    check({tag, "_err"},    64'(bus.err_o),       0);
    check({tag, "_result"}, 64'(bus.result_o),    0);
    check({tag, "_zero"},   64'(bus.zero_o),      0);
    check({tag, "_d1"},     64'(bus.alu_data1_o), 0);
    check({tag, "_d2"},     64'(bus.alu_data2_o), 0);
    check({tag, "_ctrl"},   64'(bus.alu_ctrl_o),  0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive0(1'b0, 3'b000, 0, 0);
    drive1(1'b0, 3'b000, 0, 0);
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  logic [31:0] exp_res [2];

  initial begin
    drive0(1'b0, 3'b000, 0, 0);
    drive1(1'b0, 3'b000, 0, 0);

    // Reset state.
    do_reset();
    rst_i = 1'b1;
    #1;
    check_all_zero("rst");
    rst_i = 1'b0;

    // Single request: add 5+7.
    drive0(1'b1, 3'b010, 5, 7);
    tick();
    check("t1_gnt0", 64'(bus.gnt0_o), 1);
    check("t1_gnt1", 64'(bus.gnt1_o), 0);
    check("t1_done0_early", 64'(bus.done0_o), 0);
    drive0(1'b0, 3'b010, 5, 7);
    tick();
    check("t1_done0", 64'(bus.done0_o), 1);
    check("t1_gnt0_off", 64'(bus.gnt0_o), 0);
    check("t1_result", 64'(bus.result_o), 12);
    check("t1_zero", 64'(bus.zero_o), 0);
    check("t1_err", 64'(bus.err_o), 0);
    tick();
    check("t1_done0_off", 64'(bus.done0_o), 0);
    check("t1_result_hold", 64'(bus.result_o), 12);

    // Contention after reset: requester 0 first.
    do_reset();
    drive0(1'b1, 3'b011, 9, 9);
    drive1(1'b1, 3'b001, 32'h0F, 32'hF0);
    tick();
    check("t2_gnt0", 64'(bus.gnt0_o), 1);
    check("t2_gnt1", 64'(bus.gnt1_o), 0);
    drive0(1'b0, 3'b011, 9, 9);
    tick();
    check("t2_done0", 64'(bus.done0_o), 1);
    check("t2_done1_early", 64'(bus.done1_o), 0);
    check("t2_result0", 64'(bus.result_o), 0);
    check("t2_zero0", 64'(bus.zero_o), 1);
    tick();
    check("t2_gnt1_b", 64'(bus.gnt1_o), 1);
    check("t2_done0_off", 64'(bus.done0_o), 0);
    drive1(1'b0, 3'b001, 32'h0F, 32'hF0);
    tick();
    check("t2_done1", 64'(bus.done1_o), 1);
    check("t2_result1", 64'(bus.result_o), 32'hFF);
    check("t2_zero1", 64'(bus.zero_o), 0);

    // Both held for four ops: grants alternate 0,1,0,1.
    exp_res[0] = 32'h0000_00F0;
    exp_res[1] = 32'd123;
    drive0(1'b1, 3'b000, 32'hF0F0, 32'h0FF0);
    drive1(1'b1, 3'b010, 100, 23);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t3_gnt0_%0d", i), 64'(bus.gnt0_o), 64'(i % 2 == 0));
      check($sformatf("t3_gnt1_%0d", i), 64'(bus.gnt1_o), 64'(i % 2 == 1));
      tick();
      check($sformatf("t3_done0_%0d", i), 64'(bus.done0_o), 64'(i % 2 == 0));
      check($sformatf("t3_done1_%0d", i), 64'(bus.done1_o), 64'(i % 2 == 1));
      check($sformatf("t3_gnt_off_%0d", i), 64'({bus.gnt1_o, bus.gnt0_o}), 0);
      check($sformatf("t3_result_%0d", i), 64'(bus.result_o), 64'(exp_res[i % 2]));
    end

    // Multiply 3*4 held for MUL_LAT cycles; req0 raised mid-op waits.
    drive0(1'b0, 3'b000, 0, 0);
    drive1(1'b1, 3'b100, 3, 4);
    tick();
    check("t4_gnt1", 64'(bus.gnt1_o), 1);
    drive1(1'b0, 3'b100, 3, 4);
    drive0(1'b1, 3'b010, 1, 1);
    for (int i = 1; i <= MUL_LAT; i++) begin
      if (i < MUL_LAT) begin
        check($sformatf("t4_d1_%0d", i), 64'(bus.alu_data1_o), 3);
        check($sformatf("t4_d2_%0d", i), 64'(bus.alu_data2_o), 4);
        check($sformatf("t4_ctrl_%0d", i), 64'(bus.alu_ctrl_o), 3'b100);
      end
      tick();
      check($sformatf("t4_done1_%0d", i), 64'(bus.done1_o), 64'(i == MUL_LAT));
      check($sformatf("t4_gnt0_%0d", i), 64'(bus.gnt0_o), 0);
    end
    check("t4_result", 64'(bus.result_o), 12);
    tick();
    check("t4_gnt0_after", 64'(bus.gnt0_o), 1);
    drive0(1'b0, 3'b010, 1, 1);
    tick();
    check("t4_done0", 64'(bus.done0_o), 1);
    check("t4_result0", 64'(bus.result_o), 2);

    // Illegal op 110 on requester 0.
    drive0(1'b1, 3'b110, 32'h55, 32'h33);
    tick();
    check("t5_gnt0", 64'(bus.gnt0_o), 1);
    check("t5_ctrl", 64'(bus.alu_ctrl_o), 0);
    check("t5_err_early", 64'(bus.err_o), 0);
    drive0(1'b0, 3'b110, 32'h55, 32'h33);
    tick();
    check("t5_done0", 64'(bus.done0_o), 1);
    check("t5_err", 64'(bus.err_o), 1);
    check("t5_result", 64'(bus.result_o), 0);
    check("t5_zero", 64'(bus.zero_o), 1);
    tick();
    check("t5_err_off", 64'(bus.err_o), 0);

    // Reset in the middle of a multiply.
    drive1(1'b1, 3'b100, 6, 7);
    tick();
    check("t6_gnt1", 64'(bus.gnt1_o), 1);
    drive1(1'b0, 3'b100, 6, 7);
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("t6_async");
    repeat (MUL_LAT) begin
      tick();
      check("t6_no_done1", 64'(bus.done1_o), 0);
    end
    rst_i = 1'b0;
    drive0(1'b1, 3'b010, 2, 2);
    drive1(1'b1, 3'b010, 3, 3);
    tick();
    check("t6_gnt0", 64'(bus.gnt0_o), 1);
    check("t6_gnt1", 64'(bus.gnt1_o), 0);
    drive0(1'b0, 3'b010, 2, 2);
    drive1(1'b0, 3'b010, 3, 3);
    tick();
    check("t6_done0", 64'(bus.done0_o), 1);
    check("t6_result", 64'(bus.result_o), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
